// File: rtl/nco_chan_sched_pkg.sv
// Shared constants, types and LFSR helpers for the NCO channel scheduler.
package nco_pkg;

   localparam int unsigned NCH        = 4;
   localparam int unsigned PHW        = 32;
   localparam int unsigned ANGLE_W    = 20;
   localparam int unsigned SINCOS_LAT = 7;

   typedef logic [$clog2(NCH)-1:0] ch_t;
   typedef logic [PHW-1:0]         phase_t;
   typedef logic [ANGLE_W-1:0]     angle_t;
   typedef logic [18:0]            smag19_t;

   typedef struct packed {
      logic valid;
      ch_t  ch;
   } tag_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   // x^16+x^14+x^13+x^11+1 in right-shift Fibonacci form taps bits 0,2,3,5
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {^(s & LFSR_TAPS), s[15:1]};
   endfunction

endpackage

// File: rtl/nco_chan_sched_if.sv
// Frequency-write handshake and tagged sin/cos sample bus of the NCO scheduler.
interface nco_chan_sched_if #(
   parameter int unsigned NCH = nco_pkg::NCH,
   parameter int unsigned PHW = nco_pkg::PHW
);
   localparam int unsigned CHW = $clog2(NCH);

   logic           freq_wr_valid;
   logic           freq_wr_ready;
   logic [CHW-1:0] freq_wr_ch;
   logic [PHW-1:0] freq_wr_data;

   logic           out_valid;
   logic [CHW-1:0] out_ch;
   logic [18:0]    out_sin;
   logic [18:0]    out_cos;
   logic           out_frame;

   modport master (
      output freq_wr_valid, freq_wr_ch, freq_wr_data,
      input  freq_wr_ready,
      input  out_valid, out_ch, out_sin, out_cos, out_frame
   );

   modport slave (
      input  freq_wr_valid, freq_wr_ch, freq_wr_data,
      output freq_wr_ready,
      output out_valid, out_ch, out_sin, out_cos, out_frame
   );

endinterface

// File: rtl/nco_chan_sched_tag_pipe.sv
// Channel-tag delay line matching the shared sincos pipeline latency.
module nco_tag_pipe
   import nco_pkg::*;
#(
   parameter int unsigned DEPTH = SINCOS_LAT,
   parameter type         T     = tag_t
) (
   input  logic clk,
   input  logic rst,
   input  T     tag_in,
   output T     tag_out
);

   T [DEPTH-1:0] stage;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage <= '0;
      end else begin
         stage <= {stage[DEPTH-2:0], tag_in};
      end
   end

   assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/nco_chan_sched.sv
// Round-robin NCO scheduler sharing one sincos pipeline across NCH channels.
// Optional angle dithering is enabled by defining NCO_PHASE_DITHER_EN.
module nco_chan_sched #(
   parameter int unsigned NCH        = nco_pkg::NCH,
   parameter int unsigned PHW        = nco_pkg::PHW,
   parameter int unsigned ANGLE_W    = nco_pkg::ANGLE_W,
   parameter int unsigned SINCOS_LAT = nco_pkg::SINCOS_LAT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run,
   input  logic [NCH-1:0]       phase_clr,
   output logic [ANGLE_W-1:0]   angle,
   input  nco_pkg::smag19_t     sin_in,
   input  nco_pkg::smag19_t     cos_in,
   output logic                 busy,
   nco_chan_sched_if.slave      bus
);
   import nco_pkg::*;

   localparam int unsigned CHW   = $clog2(NCH);
   localparam int unsigned CNT_W = $clog2(SINCOS_LAT + 2);
   localparam logic [CHW-1:0] SLOT_LAST = CHW'(NCH - 1);
   localparam logic [CHW-1:0] SLOT_PEN  = CHW'(NCH - 2);

   typedef struct packed {
      logic           valid;
      logic [CHW-1:0] ch;
   } ctag_t;

   state_t            state;
   logic [CHW-1:0]    slot;
   logic [CNT_W-1:0]  drain_cnt;
   logic [PHW-1:0]    phase_v  [NCH];
   logic [NCH-1:0]    pending;
   logic [NCH-1:0]    clr_pend;
   logic [NCH-1:0]    wr_mask;
   logic [ANGLE_W-1:0] angle_nx;
   logic              issue;
   logic              commit;
   logic              wr_acc;
   ctag_t             tag_q;
   ctag_t             tag_d;

   assign issue  = (state == RUN);
   assign commit = (state != RUN) || (slot == SLOT_LAST);
   assign wr_acc = bus.freq_wr_valid && bus.freq_wr_ready;

   always_comb begin
      wr_mask = '0;
      if (wr_acc) wr_mask = NCH'(1) << bus.freq_wr_ch;
   end

`ifdef NCO_PHASE_DITHER_EN
   localparam int unsigned DITH_W = PHW - ANGLE_W;
   logic [15:0]    lfsr;
   logic [PHW-1:0] dith_sum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr <= LFSR_SEED;
      end else if (issue) begin
         lfsr <= lfsr_next(lfsr);
      end
   end

   always_comb begin
      dith_sum = phase_v[slot] + PHW'(lfsr[DITH_W-1:0]);
      angle_nx = ANGLE_W'(dith_sum >> DITH_W);
   end
`else
   always_comb begin
      angle_nx = phase_v[slot][PHW-1 -: ANGLE_W];
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= IDLE;
         slot              <= '0;
         drain_cnt         <= '0;
         busy              <= 1'b0;
         bus.freq_wr_ready <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (run) begin
                  state <= RUN;
                  slot  <= '0;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               slot              <= slot + 1'b1;
               // ready is blocked exactly while the commit slot is current
               bus.freq_wr_ready <= (slot != SLOT_PEN);
               if (slot == SLOT_LAST && !run) begin
                  state     <= DRAIN;
                  drain_cnt <= CNT_W'(SINCOS_LAT + 1);
               end
            end
            DRAIN: begin
               if (run) begin
                  state <= RUN;
                  slot  <= '0;
               end else if (drain_cnt == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  drain_cnt <= drain_cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending  <= '0;
         clr_pend <= '0;
      end else begin
         // requests landing on a commit edge survive to the following commit
         pending  <= (commit ? '0 : pending)  | wr_mask;
         clr_pend <= (commit ? '0 : clr_pend) | phase_clr;
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic [PHW-1:0] phase_q;
      logic [PHW-1:0] freq_active;
      logic [PHW-1:0] freq_shadow;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            phase_q     <= '0;
            freq_active <= '0;
            freq_shadow <= '0;
         end else begin
            if (issue && slot == CHW'(g)) phase_q <= phase_q + freq_active;
            if (commit && clr_pend[g])    phase_q <= '0;
            if (commit && pending[g])     freq_active <= freq_shadow;
            if (wr_mask[g])               freq_shadow <= bus.freq_wr_data;
         end
      end

      assign phase_v[g] = phase_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         angle <= '0;
         tag_q <= '0;
      end else begin
         tag_q <= '0;
         if (issue) begin
            angle <= angle_nx;
            tag_q <= {1'b1, slot};
         end
      end
   end

   nco_tag_pipe #(
      .DEPTH (SINCOS_LAT),
      .T     (ctag_t)
   ) u_tag_pipe (
      .clk     (clk),
      .rst     (rst),
      .tag_in  (tag_q),
      .tag_out (tag_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.out_frame <= 1'b0;
         bus.out_ch    <= '0;
         bus.out_sin   <= '0;
         bus.out_cos   <= '0;
      end else begin
         bus.out_valid <= tag_d.valid;
         bus.out_frame <= tag_d.valid && (tag_d.ch == '0);
         if (tag_d.valid) begin
            bus.out_ch  <= tag_d.ch;
            bus.out_sin <= sin_in;
            bus.out_cos <= cos_in;
         end
      end
   end

endmodule

// File: tb/tb_nco_chan_sched.sv
// Directed bench for nco_chan_sched: per-cycle vector table plus reset sequences.
module tb_nco_chan_sched;
   import nco_pkg::*;

   localparam int unsigned CHW = $clog2(NCH);
   localparam int NV = 35;

   logic               clk = 1'b0;
   logic               rst;
   logic               run;
   logic [NCH-1:0]     phase_clr;
   logic [ANGLE_W-1:0] angle;
   logic [18:0]        sin_in;
   logic [18:0]        cos_in;
   logic               busy;

   nco_chan_sched_if #(.NCH(NCH), .PHW(PHW)) bus ();

   nco_chan_sched #(
      .NCH        (NCH),
      .PHW        (PHW),
      .ANGLE_W    (ANGLE_W),
      .SINCOS_LAT (SINCOS_LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .phase_clr (phase_clr),
      .angle     (angle),
      .sin_in    (sin_in),
      .cos_in    (cos_in),
      .busy      (busy),
      .bus       (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic               run;
      logic               wr_valid;
      logic [CHW-1:0]     wr_ch;
      logic [PHW-1:0]     wr_data;
      logic [NCH-1:0]     clr;
      logic [ANGLE_W-1:0] e_angle;
      logic               e_ready;
      logic               e_busy;
      logic               e_valid;
      logic               e_frame;
      logic [CHW-1:0]     e_ch;
   } vec_t;

   vec_t        vt [NV];
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic        got;
   logic [15:0] g_lfsr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] gold_step(input logic [15:0] s);
      logic fb;
      fb = s[0] ^ s[2] ^ s[3] ^ s[5];
      return {fb, s[15:1]};
   endfunction

   initial begin
      rst               = 1'b1;
      run               = 1'b0;
      phase_clr         = '0;
      bus.freq_wr_valid = 1'b0;
      bus.freq_wr_ch    = '0;
      bus.freq_wr_data  = '0;
      sin_in            = '0;
      cos_in            = '0;

      repeat (2) tick();
      chk("rst angle", 32'(angle), 32'h0);
      chk("rst out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst busy", 32'(busy), 32'h0);
      chk("rst ready", 32'(bus.freq_wr_ready), 32'h1);
      chk("rst out_sin", 32'(bus.out_sin), 32'h0);
`ifdef NCO_PHASE_DITHER_EN
      chk("lfsr seed", 32'(dut.lfsr), 32'(16'hACE1));
`endif
      rst = 1'b0;
      tick();
      chk("idle busy", 32'(busy), 32'h0);

      // frequency writes while idle: committed on the next edge
      bus.freq_wr_valid = 1'b1;
      bus.freq_wr_ch    = CHW'(1);
      bus.freq_wr_data  = 32'h1000_0000;
      tick();
      chk("idle ready", 32'(bus.freq_wr_ready), 32'h1);
      bus.freq_wr_ch    = CHW'(3);
      bus.freq_wr_data  = 32'h8000_0000;
      tick();
      bus.freq_wr_valid = 1'b0;
      repeat (2) tick();

      // record k: inputs applied before edge k, expectations sampled after it
      for (int k = 0; k < NV; k++) begin
         vt[k].run      = (k <= 21);
         vt[k].wr_valid = (k == 8 || k == 9);
         vt[k].wr_ch    = CHW'(2);
         vt[k].wr_data  = 32'h0400_0000;
         vt[k].clr      = (k == 10) ? 4'b1000 : 4'b0000;
         vt[k].e_angle  = '0;
         vt[k].e_busy   = (k <= 32);
         vt[k].e_ready  = !(k >= 3 && k <= 23 && (k % 4) == 3);
         vt[k].e_valid  = (k >= 9 && k <= 32);
         vt[k].e_ch     = CHW'((k + 3) % 4);
         vt[k].e_frame  = (k >= 9 && k <= 32) && ((k + 3) % 4 == 0);
      end
      vt[6].e_angle  = 20'h10000;
      vt[10].e_angle = 20'h20000;
      vt[14].e_angle = 20'h30000;
      vt[18].e_angle = 20'h40000;
      vt[22].e_angle = 20'h50000;
      vt[19].e_angle = 20'h04000;
      vt[23].e_angle = 20'h08000;
      vt[8].e_angle  = 20'h80000;
      vt[20].e_angle = 20'h80000;

      for (int k = 0; k < NV; k++) begin
         run               = vt[k].run;
         bus.freq_wr_valid = vt[k].wr_valid;
         bus.freq_wr_ch    = vt[k].wr_ch;
         bus.freq_wr_data  = vt[k].wr_data;
         phase_clr         = vt[k].clr;
         sin_in            = 19'h10000 + 19'(k);
         cos_in            = 19'h40000 | 19'(k);
         tick();
         chk($sformatf("v%0d angle", k), 32'(angle), 32'(vt[k].e_angle));
         chk($sformatf("v%0d ready", k), 32'(bus.freq_wr_ready), 32'(vt[k].e_ready));
         chk($sformatf("v%0d busy", k), 32'(busy), 32'(vt[k].e_busy));
         chk($sformatf("v%0d out_valid", k), 32'(bus.out_valid), 32'(vt[k].e_valid));
         chk($sformatf("v%0d out_frame", k), 32'(bus.out_frame), 32'(vt[k].e_frame));
         if (vt[k].e_valid) begin
            chk($sformatf("v%0d out_ch", k), 32'(bus.out_ch), 32'(vt[k].e_ch));
            chk($sformatf("v%0d out_sin", k), 32'(bus.out_sin), 32'(19'h10000 + 19'(k)));
            chk($sformatf("v%0d out_cos", k), 32'(bus.out_cos), 32'(19'h40000 | 19'(k)));
         end
      end
      bus.freq_wr_valid = 1'b0;
      phase_clr         = '0;

`ifdef NCO_PHASE_DITHER_EN
      g_lfsr = 16'hACE1;
      for (int i = 0; i < 24; i++) g_lfsr = gold_step(g_lfsr);
      chk("lfsr after 24 issues", 32'(dut.lfsr), 32'(g_lfsr));
`endif

      // restart, then hit reset asynchronously while samples are in flight
      run = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         tick();
         if (bus.out_valid) got = 1'b1;
      end
      chk("restart out_valid seen", 32'(got), 32'h1);
      repeat (3) tick();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("async rst angle", 32'(angle), 32'h0);
      chk("async rst out_valid", 32'(bus.out_valid), 32'h0);
      chk("async rst busy", 32'(busy), 32'h0);
      chk("async rst ready", 32'(bus.freq_wr_ready), 32'h1);
      repeat (2) tick();
      chk("held rst out_valid", 32'(bus.out_valid), 32'h0);
      chk("held rst busy", 32'(busy), 32'h0);
      rst = 1'b0;
      run = 1'b0;
      tick();
      chk("post rst busy", 32'(busy), 32'h0);
      chk("post rst ready", 32'(bus.freq_wr_ready), 32'h1);
      chk("post rst angle", 32'(angle), 32'h0);
      run = 1'b1;
      repeat (3) tick();
      chk("post rst ch1 angle", 32'(angle), 32'h0);
      chk("post rst out_valid", 32'(bus.out_valid), 32'h0);
      run = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/nco_chan_sched.md
Name: nco_chan_sched

Overview:
- Time-multiplexes one shared sincos pipeline (20-bit angle in; 19-bit sign-magnitude sin/cos out) across NCH receive-channel NCOs.
- Holds a phase accumulator and a frequency word per channel, and issues one channel angle per clock in round-robin order.
- Tags every issue with its channel index, aligns the tag to the sincos pipeline latency and presents tagged sin/cos to the DDC mixers.
- Frequency and phase-clear updates take effect coherently at frame boundaries.

Parameters:
- NCH, 4: number of channels; power of two, 2..16.
- PHW, 32: phase accumulator and frequency word width.
- ANGLE_W, 20: angle width driven to sincos.
- SINCOS_LAT, 7: clocks from angle change to corresponding sin_in/cos_in.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- run  in  1  level; enable scheduling.
- freq_wr_valid  in  1  frequency write request.
- freq_wr_ready  out  1  write accepted when valid&&ready.
- freq_wr_ch  in  $clog2(NCH)  target channel.
- freq_wr_data  in  PHW  frequency word.
- phase_clr  in  NCH  one-cycle pulses; request phase zero per channel.
- angle  out  ANGLE_W  registered angle to sincos.
- sin_in  in  19  sincos sin result.
- cos_in  in  19  sincos cos result.
- out_valid  out  1  tagged sample valid.
- out_ch  out  $clog2(NCH)  channel of sample.
- out_sin  out  19  sample sin, sign-magnitude passthrough.
- out_cos  out  19  sample cos, sign-magnitude passthrough.
- out_frame  out  1  high with out_valid when out_ch==0.
- busy  out  1  state!=IDLE.

Behaviour:
- Reset values:
  - angle, out_*, phase[], freq_active[], freq_shadow[], pending flags, clear flags, tag pipe, slot: all 0.
  - State IDLE.
  - freq_wr_ready=1 and busy=0 after reset.
- State machine: IDLE, RUN, DRAIN.
  - IDLE->RUN when run=1; slot starts at 0.
  - RUN: slot increments every clock, wrapping at NCH-1. At slot==NCH-1: if run=0 go to DRAIN, else stay in RUN. A drop of run mid-frame always completes the frame.
  - DRAIN: counter loads SINCOS_LAT+1 and decrements. Go to IDLE at 0. If run=1 in DRAIN, go to RUN at slot 0 directly.
- Issue (RUN only), cycle with slot=s:
  - angle <= phase[s][PHW-1 -: ANGLE_W] (truncation).
  - phase[s] <= phase[s]+freq_active[s], modulo 2^PHW.
  - A tag {1,s} enters the tag pipe.
- Latency: the sample whose angle is visible at cycle n appears on out_* at cycle n+SINCOS_LAT+1. out_sin and out_cos are registered from sin_in/cos_in when the delayed tag is valid; otherwise out_valid=0 and the data holds.
- Frequency writes:
  - Accepted into freq_shadow[ch], with pending[ch] set. A later write to the same channel overwrites the shadow.
  - freq_wr_ready = !(state==RUN && slot==NCH-1); writes never coincide with a commit.
- phase_clr[i] sets clr_pend[i]. A pulse that coincides with a commit is held until the next commit.
- Commit:
  - In RUN, commit happens on the slot==NCH-1 edge. In IDLE/DRAIN, it happens on every edge.
  - For each pending channel: freq_active <= freq_shadow, and the pending flag clears.
  - For each clr_pend channel: phase <= 0, overriding that cycle's accumulate.
- Async rst mid-run: everything returns to reset values immediately. In-flight samples are discarded and out_valid=0.

Optional Feature:
NCO_PHASE_DITHER_EN:
- Defined: a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, reset seed 16'hACE1) advances once per issue. angle = (phase + zero-extended lfsr[PHW-ANGLE_W-1:0])[PHW-1 -: ANGLE_W], discarding the carry out of the MSB.
- Undefined: plain truncation; no LFSR is present.

Decomposition:
- Package nco_pkg holds:
  - NCH, PHW, ANGLE_W, SINCOS_LAT default constants.
  - Typedefs ch_t, phase_t, angle_t, smag19_t.
  - tag_t {valid, ch}.
  - LFSR seed/taps constants.
- One sub-module, nco_tag_pipe: SINCOS_LAT-deep shift register of tag_t with async reset.

Test Plan:
- Reset: assert rst mid-stream -> angle=0, out_valid=0, busy=0, freq_wr_ready=1 during and after reset.
- NCH=4, dither off, freq ch1=32'h1000_0000, run=1 -> ch1 angles 20'h00000, 20'h10000, 20'h20000 in successive frames; out_ch cycles 0,1,2,3; out_valid continuous; out_frame on ch0.
- Write to ch2 presented when slot==3 -> freq_wr_ready=0 that cycle; accepted at the next cycle; the new frequency takes effect one frame after acceptance.
- freq ch3=32'h8000_0000 -> ch3 angle alternates 20'h00000/20'h80000 (wrap check); phase_clr[3] pulse at slot 1 -> next frame ch3 angle=0, other channels unaffected.
- Drop run at slot 1 -> slots 2,3 still issued, state DRAIN; last out_valid at SINCOS_LAT+1 cycles after the slot-3 angle, then busy=0.
- Dither on, freq=0 all channels -> angle bits still 0 for phase 0; LFSR sequence matches golden 16'hACE1 successors.
